wb_decode_nway: RTL and testbench

//   Parametrised N-slave Wishbone address decoder with a cycle-locked slave grant,
//   an internal error responder for unmapped addresses, and a per-transfer watchdog.

---
 rtl/wb_decode_nway.sv | 219 +++++++++++++++++++++
 tb/tb_wb_decode_nway.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_decode_nway.sv
// Wishbone N-slave address decoder: mask/match decode, cycle-locked grant, error responder.
// Define WB_DECODE_TIMEOUT_EN to enable the per-transfer response watchdog.
module wb_decode_nway #(
    parameter int unsigned SLAVES         = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] MATCH_ADDR = '0,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] MATCH_MASK = '0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1,
    localparam int unsigned SEL_W = DATA_WIDTH / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_WIDTH-1:0]        m_adr_i,
    input  logic [DATA_WIDTH-1:0]        m_dat_i,
    input  logic [SEL_W-1:0]             m_sel_i,
    input  logic                         m_we_i,
    input  logic [2:0]                   m_cti_i,
    input  logic [1:0]                   m_bte_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    output logic [DATA_WIDTH-1:0]        m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic                         m_rty_o,
    output logic [SLAVES*ADDR_WIDTH-1:0] s_adr_o,
    output logic [SLAVES*DATA_WIDTH-1:0] s_dat_o,
    output logic [SLAVES*SEL_W-1:0]      s_sel_o,
    output logic [SLAVES-1:0]            s_we_o,
    output logic [SLAVES*3-1:0]          s_cti_o,
    output logic [SLAVES*2-1:0]          s_bte_o,
    output logic [SLAVES-1:0]            s_cyc_o,
    output logic [SLAVES-1:0]            s_stb_o,
    input  logic [SLAVES*DATA_WIDTH-1:0] s_dat_i,
    input  logic [SLAVES-1:0]            s_ack_i,
    input  logic [SLAVES-1:0]            s_err_i,
    input  logic [SLAVES-1:0]            s_rty_i,
    output logic                         busy_o,
    output logic                         decode_err_o,
    output logic                         timeout_o,
    output logic [IDX_W-1:0]             err_idx_o
);

    typedef enum logic [1:0] {StIdle, StActive, StErr} state_t;
    typedef enum logic {KindDecode, KindTimeout} err_kind_t;

    state_t     state, state_next;
    err_kind_t  err_kind, err_kind_next;
    logic [IDX_W-1:0] sel_idx, sel_idx_next;
    logic [SLAVES-1:0] hit;
    logic [IDX_W-1:0]  win_idx;
    logic              hit_any;
    logic              req;
    logic              timeout_hit;
    logic              route_en;
    logic [IDX_W-1:0]  route_idx;

    assign s_adr_o = {SLAVES{m_adr_i}};
    assign s_dat_o = {SLAVES{m_dat_i}};
    assign s_sel_o = {SLAVES{m_sel_i}};
    assign s_we_o  = {SLAVES{m_we_i}};
    assign s_cti_o = {SLAVES{m_cti_i}};
    assign s_bte_o = {SLAVES{m_bte_i}};

    assign req = m_cyc_i & m_stb_i;

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(SLAVES); i++) begin
            hit[i] = (m_adr_i & MATCH_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                     (MATCH_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] &
                      MATCH_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        win_idx = '0;
        for (int i = int'(SLAVES) - 1; i >= 0; i--) begin
            if (hit[i]) win_idx = IDX_W'(i);
        end
    end

    assign hit_any = |hit;

`ifdef WB_DECODE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] CNT_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt, cnt_next;
    logic            act_resp, win_resp;

    assign act_resp = s_ack_i[sel_idx] | s_err_i[sel_idx] | s_rty_i[sel_idx];
    assign win_resp = s_ack_i[win_idx] | s_err_i[win_idx] | s_rty_i[win_idx];
    // A response in the limit cycle wins over the watchdog.
    assign timeout_hit = (state == StActive) && m_cyc_i && !act_resp && (cnt == CNT_LIMIT);

    always_comb begin
        cnt_next = cnt;
        case (state)
            StIdle: begin
                if (req && hit_any) cnt_next = win_resp ? '0 : TO_W'(1);
            end
            StActive: begin
                if (act_resp) cnt_next = '0;
                else if (m_stb_i) cnt_next = cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            err_idx_o <= '0;
        end else begin
            cnt <= cnt_next;
            if (state == StErr && err_kind == KindTimeout) err_idx_o <= sel_idx;
        end
    end

    assign timeout_o = (state == StErr) && (err_kind == KindTimeout);
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
    assign err_idx_o   = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= StIdle;
            sel_idx  <= '0;
            err_kind <= KindDecode;
        end else begin
            state    <= state_next;
            sel_idx  <= sel_idx_next;
            err_kind <= err_kind_next;
        end
    end

    always_comb begin
        state_next    = state;
        sel_idx_next  = sel_idx;
        err_kind_next = err_kind;
        case (state)
            StIdle: begin
                if (req) begin
                    if (hit_any) begin
                        state_next   = StActive;
                        sel_idx_next = win_idx;
                    end else begin
                        state_next    = StErr;
                        err_kind_next = KindDecode;
                    end
                end
            end
            StActive: begin
                if (!m_cyc_i) begin
                    state_next = StIdle;
                end else if (timeout_hit) begin
                    state_next    = StErr;
                    err_kind_next = KindTimeout;
                end
            end
            StErr:   state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_comb begin
        s_cyc_o   = '0;
        s_stb_o   = '0;
        m_ack_o   = 1'b0;
        m_err_o   = 1'b0;
        m_rty_o   = 1'b0;
        m_dat_o   = '0;
        route_en  = 1'b0;
        route_idx = sel_idx;
        case (state)
            StIdle: begin
                if (req && hit_any) begin
                    route_en          = 1'b1;
                    route_idx         = win_idx;
                    s_cyc_o[win_idx]  = 1'b1;
                    s_stb_o[win_idx]  = 1'b1;
                end
            end
            StActive: begin
                route_en         = 1'b1;
                s_cyc_o[sel_idx] = m_cyc_i;
                s_stb_o[sel_idx] = m_stb_i;
            end
            StErr:   m_err_o = 1'b1;
            default: ;
        endcase
        if (route_en) begin
            m_ack_o = s_ack_i[route_idx];
            m_err_o = s_err_i[route_idx];
            m_rty_o = s_rty_i[route_idx];
            m_dat_o = s_dat_i[route_idx*DATA_WIDTH +: DATA_WIDTH];
        end
        // Reset abandons any in-flight transfer without a response.
        if (rst_i) begin
            s_cyc_o = '0;
            s_stb_o = '0;
            m_ack_o = 1'b0;
            m_err_o = 1'b0;
            m_rty_o = 1'b0;
            m_dat_o = '0;
        end
    end

    assign busy_o       = (state != StIdle);
    assign decode_err_o = (state == StErr) && (err_kind == KindDecode);

endmodule

// File: tb/tb_wb_decode_nway.sv
// Directed self-checking bench for wb_decode_nway (4 slaves, 16-cycle watchdog when enabled).
module tb_wb_decode_nway;

    localparam int unsigned SLAVES = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [AW-1:0] m_adr_i = '0;
    logic [DW-1:0] m_dat_i = '0;
    logic [3:0]    m_sel_i = 4'hF;
    logic          m_we_i  = 1'b0;
    logic [2:0]    m_cti_i = 3'b000;
    logic [1:0]    m_bte_i = 2'b00;
    logic          m_cyc_i = 1'b0;
    logic          m_stb_i = 1'b0;
    logic [DW-1:0] m_dat_o;
    logic          m_ack_o, m_err_o, m_rty_o;
    logic [SLAVES*AW-1:0] s_adr_o;
    logic [SLAVES*DW-1:0] s_dat_o;
    logic [SLAVES*4-1:0]  s_sel_o;
    logic [SLAVES-1:0]    s_we_o;
    logic [SLAVES*3-1:0]  s_cti_o;
    logic [SLAVES*2-1:0]  s_bte_o;
    logic [SLAVES-1:0]    s_cyc_o, s_stb_o;
    logic [SLAVES*DW-1:0] s_dat_i = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    logic [SLAVES-1:0]    s_ack_i = '0;
    logic [SLAVES-1:0]    s_err_i = '0;
    logic [SLAVES-1:0]    s_rty_i = '0;
    logic                 busy_o, decode_err_o, timeout_o;
    logic [1:0]           err_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    // Slave 1 also covers 0x3xxx_xxxx, overlapping slave 3.
    wb_decode_nway #(
        .SLAVES         (SLAVES),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MATCH_ADDR     ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .MATCH_MASK     ({32'hF000_0000, 32'hF000_0000, 32'hD000_0000, 32'hF000_0000}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m_adr_i      (m_adr_i),
        .m_dat_i      (m_dat_i),
        .m_sel_i      (m_sel_i),
        .m_we_i       (m_we_i),
        .m_cti_i      (m_cti_i),
        .m_bte_i      (m_bte_i),
        .m_cyc_i      (m_cyc_i),
        .m_stb_i      (m_stb_i),
        .m_dat_o      (m_dat_o),
        .m_ack_o      (m_ack_o),
        .m_err_o      (m_err_o),
        .m_rty_o      (m_rty_o),
        .s_adr_o      (s_adr_o),
        .s_dat_o      (s_dat_o),
        .s_sel_o      (s_sel_o),
        .s_we_o       (s_we_o),
        .s_cti_o      (s_cti_o),
        .s_bte_o      (s_bte_o),
        .s_cyc_o      (s_cyc_o),
        .s_stb_o      (s_stb_o),
        .s_dat_i      (s_dat_i),
        .s_ack_i      (s_ack_i),
        .s_err_i      (s_err_i),
        .s_rty_i      (s_rty_i),
        .busy_o       (busy_o),
        .decode_err_o (decode_err_o),
        .timeout_o    (timeout_o),
        .err_idx_o    (err_idx_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_idle();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_cti_i = 3'b000;
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        // Reset: outputs gated even while the master strobes a mapped address.
        #2;
        m_adr_i = 32'h2000_0000;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        s_ack_i = 4'b0100;
        #1;
        check("rst_stb", s_stb_o, 4'b0000);
        check("rst_cyc", s_cyc_o, 4'b0000);
        check("rst_ack", m_ack_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_flags", {decode_err_o, timeout_o, err_idx_o}, 4'b0000);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        next_cycle();
        rst_i = 1'b0;
        next_cycle();

        // 1: zero-latency read from slave 2.
        m_adr_i = 32'h2000_0010;
        m_dat_i = 32'h1234_5678;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        s_ack_i = 4'b0100;
        #1;
        check("t1_stb", s_stb_o, 4'b0100);
        check("t1_cyc", s_cyc_o, 4'b0100);
        check("t1_ack", m_ack_o, 1'b1);
        check("t1_dat", m_dat_o, 32'hA000_0002);
        check("t1_busy0", busy_o, 1'b0);
        check("t1_badr", s_adr_o, {4{32'h2000_0010}});
        check("t1_bdat", s_dat_o, {4{32'h1234_5678}});
        next_cycle();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        #1;
        check("t1_busy1", busy_o, 1'b1);
        check("t1_stb_off", s_stb_o, 4'b0000);
        bus_idle();
        check("t1_idle", busy_o, 1'b0);

        // 2: overlap, slave 1 wins over slave 3; responses only from slave 1.
        m_adr_i = 32'h3000_0000;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        s_ack_i = 4'b1000;
        #1;
        check("t2_stb", s_stb_o, 4'b0010);
        check("t2_ack_s3", m_ack_o, 1'b0);
        next_cycle();
        s_ack_i = 4'b0010;
        #1;
        check("t2_stb_act", s_stb_o, 4'b0010);
        check("t2_ack_s1", m_ack_o, 1'b1);
        check("t2_dat", m_dat_o, 32'hA000_0001);
        bus_idle();

        // 3: unmapped address, error on cycle 1 only, master drops cyc during ERR.
        m_adr_i = 32'hF000_0000;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        #1;
        check("t3_stb0", s_stb_o, 4'b0000);
        check("t3_err0", {m_err_o, decode_err_o}, 2'b00);
        next_cycle();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        #1;
        check("t3_err1", {m_err_o, decode_err_o, timeout_o}, 3'b110);
        check("t3_stb1", s_cyc_o | s_stb_o, 4'b0000);
        check("t3_ack1", m_ack_o, 1'b0);
        next_cycle();
        #1;
        check("t3_err2", {m_err_o, decode_err_o, busy_o}, 3'b000);
        bus_idle();

        // 4: silent slave 1.
        m_adr_i = 32'h1000_0000;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
`ifdef WB_DECODE_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            #1;
            check($sformatf("t4_stb_c%0d", k), {m_err_o, s_stb_o}, 5'b0_0010);
            next_cycle();
        end
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        #1;
        check("t4_err16", {m_err_o, timeout_o, decode_err_o}, 3'b110);
        check("t4_stb16", s_stb_o, 4'b0000);
        check("t4_idx16", err_idx_o, 2'd0);
        next_cycle();
        #1;
        check("t4_idx17", err_idx_o, 2'd1);
        check("t4_clr17", {m_err_o, timeout_o}, 2'b00);
        bus_idle();

        // Response in the limit cycle beats the watchdog.
        m_adr_i = 32'h2000_0000;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        for (int k = 0; k < 15; k++) next_cycle();
        s_ack_i = 4'b0100;
        #1;
        check("t4_late_ack", m_ack_o, 1'b1);
        next_cycle();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        #1;
        check("t4_no_to", {m_err_o, timeout_o, busy_o}, 3'b001);
        check("t4_idx_keep", err_idx_o, 2'd1);
        bus_idle();
`else
        for (int k = 0; k < 40; k++) next_cycle();
        #1;
        check("t4_wait_stb", s_stb_o, 4'b0010);
        check("t4_wait_err", {m_err_o, timeout_o, err_idx_o}, 4'b0000);
        s_ack_i = 4'b0010;
        #1;
        check("t4_wait_ack", m_ack_o, 1'b1);
        bus_idle();
`endif

        // 5: burst to slave 0, address wanders into slave 3's range mid-burst.
        m_adr_i = 32'h0000_0100;
        m_cti_i = 3'b010;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        s_ack_i = 4'b0001;
        #1;
        check("t5_b0", {m_ack_o, s_stb_o}, 5'b1_0001);
        next_cycle();
        m_adr_i = 32'h0000_0104;
        next_cycle();
        m_adr_i = 32'h3000_0000;
        #1;
        check("t5_b2", {m_ack_o, s_stb_o}, 5'b1_0001);
        next_cycle();
        m_adr_i = 32'h3000_0004;
        m_cti_i = 3'b111;
        #1;
        check("t5_b3", {m_ack_o, s_stb_o}, 5'b1_0001);
        check("t5_dat", m_dat_o, 32'hA000_0000);
        next_cycle();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        #1;
        check("t5_end", {busy_o, s_cyc_o}, 5'b1_0000);
        bus_idle();
        check("t5_idle", busy_o, 1'b0);

        // 6: reset during an active transfer.
        m_adr_i = 32'h2000_0000;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        next_cycle();
        #1;
        check("t6_act", {busy_o, s_stb_o}, 5'b1_0100);
        next_cycle();
        rst_i   = 1'b1;
        s_ack_i = 4'b0100;
        #1;
        check("t6_rst_s", s_cyc_o | s_stb_o, 4'b0000);
        check("t6_rst_m", {busy_o, m_ack_o}, 2'b00);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        #1;
        rst_i = 1'b0;
        next_cycle();
        m_adr_i = 32'h0000_0040;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        s_ack_i = 4'b0001;
        #1;
        check("t6_post", {m_ack_o, s_stb_o}, 5'b1_0001);
        check("t6_post_dat", m_dat_o, 32'hA000_0000);
        bus_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
